// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational 32-bit ALU
// between NUM_REQ requesters. Each accepted operation takes one cycle on the
// ALU, and its result is returned with the requester ID over a valid/ready
// response channel.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*5-1:0] req_opcode,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [4:0]           alu_opcode,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_negative,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_negative
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] grant_id_q;
  logic [31:0]     alu_a_q, alu_b_q;
  logic [4:0]      alu_opcode_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0]     rsp_result_q;
  logic            rsp_zero_q, rsp_negative_q;

  logic            gnt_valid;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;

  // Unpacked per-requester views of the flat payload buses
  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];
  logic [4:0]  op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[32*g +: 32];
    assign b_arr[g]  = req_b[32*g +: 32];
    assign op_arr[g] = req_opcode[5*g +: 5];
  end

  // Round-robin pick: first valid requester scanning upward from last_grant+1
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(last_grant_q) + 32'd1 + i) % NUM_REQ);
      if (!gnt_valid && req_valid[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in idle, one execute cycle, then wait for the consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_valid_q && rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: grant is offered only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Datapath: latch operands on accept, capture ALU result after the execute cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q   <= ID_W'(NUM_REQ - 1);  // requester 0 is next in line
      grant_id_q     <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_opcode_q   <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            alu_a_q      <= a_arr[gnt_idx];
            alu_b_q      <= b_arr[gnt_idx];
            alu_opcode_q <= op_arr[gnt_idx];
            grant_id_q   <= gnt_idx;
            last_grant_q <= gnt_idx;
          end
        end
        StExec: begin
          rsp_result_q   <= alu_result;
          rsp_zero_q     <= alu_zero;
          rsp_negative_q <= alu_negative;
          rsp_id_q       <= grant_id_q;
          rsp_valid_q    <= 1'b1;
        end
        StResp: begin
          if (rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_opcode_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_negative_q;

endmodule
